fetch_sequencer: RTL and testbench

- Multi-cycle Y86-64 instruction fetch controller for a byte-wide synchronous instruction ROM with one read per cycle.
- Accepts a PC and reads exactly the instruction's bytes, sequencing one address per cycle.
- Assembles icode/ifun/rA/rB/valC (little-endian) and valP, then presents them to decode over a valid/ready handshake.
- Holds a sticky halt when stat_in leaves AOK (3'b001).

---
 rtl/fetch_sequencer_if.sv | 42 ++++
 rtl/fetch_sequencer.sv | 157 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// ----------------------------------------------------------------------
// fetch_sequencer_if: ROM read bus, control and decode handshake of the fetch unit
// Revision 1.0
// ----------------------------------------------------------------------
`default_nettype none

interface fetch_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic [63:0]       pc_in;
  logic [2:0]        stat_in;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        icode;
  logic [3:0]        ifun;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic [63:0]       valC;
  logic [63:0]       valP;
  logic              instr_valid;
  logic              imem_error;
  logic              busy;
  logic              halted;

  modport master (
    input  start, pc_in, stat_in, mem_rdata, out_ready,
    output mem_en, mem_addr, out_valid, icode, ifun, rA, rB, valC, valP,
           instr_valid, imem_error, busy, halted
  );

  modport slave (
    output start, pc_in, stat_in, mem_rdata, out_ready,
    input  mem_en, mem_addr, out_valid, icode, ifun, rA, rB, valC, valP,
           instr_valid, imem_error, busy, halted
  );
endinterface

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------
// fetch_sequencer: multi-cycle Y86-64 instruction fetch over a byte-wide sync ROM
// Revision 1.0
// ----------------------------------------------------------------------
`default_nettype none

module fetch_sequencer #(
  parameter int ADDR_W    = 10,
  parameter int MEM_BYTES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    COLLECT = 3'd2,
    DONE    = 3'd3,
    HALT    = 3'd4
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic [3:0]  cnt;
  logic [3:0]  len;

  logic [3:0]  byte0_len;
  logic [3:0]  cur_len;
  logic [63:0] byte0_end;
  logic        pc_oob;
  logic        range_err;

  function automatic logic [3:0] instr_len(input logic [3:0] code);
    case (code)
      4'h2, 4'h6, 4'hA, 4'hB: return 4'd2;
      4'h3, 4'h4, 4'h5:       return 4'd10;
      4'h7, 4'h8:             return 4'd9;
      default:                return 4'd1;
    endcase
  endfunction

  // Byte 0 length is decoded straight off the ROM data so byte 1's read goes out in the same cycle.
  always_comb begin
    byte0_len    = instr_len(bus.mem_rdata[7:4]);
    cur_len      = (cnt == 4'd0) ? byte0_len : len;
    byte0_end    = pc + {60'd0, byte0_len};
    pc_oob       = (pc >= 64'(MEM_BYTES));
    range_err    = (cnt == 4'd0) && (byte0_end > 64'(MEM_BYTES));
    bus.mem_en   = 1'b0;
    bus.mem_addr = '0;
    if (state == ISSUE && !pc_oob) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = pc[ADDR_W-1:0];
    end else if (state == COLLECT && !range_err && ((cnt + 4'd1) < cur_len)) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = pc[ADDR_W-1:0] + ADDR_W'(cnt) + ADDR_W'(1);
    end
  end

  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == ISSUE) || (state == COLLECT) || (state == DONE);
  assign bus.halted    = (state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      pc              <= '0;
      cnt             <= '0;
      len             <= '0;
      bus.icode       <= '0;
      bus.ifun        <= '0;
      bus.rA          <= '0;
      bus.rB          <= '0;
      bus.valC        <= '0;
      bus.valP        <= '0;
      bus.instr_valid <= 1'b0;
      bus.imem_error  <= 1'b0;
    end else if (bus.stat_in != 3'b001) begin
      // Halt overrides everything, including a handshake completing this edge.
      state <= HALT;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            pc              <= bus.pc_in;
            cnt             <= '0;
            len             <= '0;
            bus.icode       <= '0;
            bus.ifun        <= '0;
            bus.rA          <= '0;
            bus.rB          <= '0;
            bus.valC        <= '0;
            bus.valP        <= '0;
            bus.instr_valid <= 1'b0;
            bus.imem_error  <= 1'b0;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          if (pc_oob) begin
            bus.imem_error <= 1'b1;
            bus.valP       <= pc;
            state          <= DONE;
          end else begin
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (cnt == 4'd0) begin
            if (range_err) begin
              bus.imem_error <= 1'b1;
              bus.valP       <= pc;
              state          <= DONE;
            end else begin
              bus.icode       <= bus.mem_rdata[7:4];
              bus.ifun        <= bus.mem_rdata[3:0];
              bus.instr_valid <= (bus.mem_rdata[7:4] <= 4'hB);
              len             <= byte0_len;
              if (byte0_len == 4'd1) begin
                bus.valP <= byte0_end;
                state    <= DONE;
              end else begin
                cnt <= 4'd1;
              end
            end
          end else begin
            if ((len == 4'd2 || len == 4'd10) && cnt == 4'd1) begin
              {bus.rA, bus.rB} <= bus.mem_rdata;
            end
            // Constant bytes arrive LSB first; shifting in from the top leaves them little-endian.
            if (len == 4'd9 || (len == 4'd10 && cnt >= 4'd2)) begin
              bus.valC <= {bus.mem_rdata, bus.valC[63:8]};
            end
            if (cnt == len - 4'd1) begin
              bus.valP <= pc + {60'd0, len};
              state    <= DONE;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ----------------------------------------------------------------------
// tb_fetch_sequencer: vector table, corner sequences and random fetches vs a reference model
// Revision 1.0
// ----------------------------------------------------------------------
`default_nettype none

module tb_fetch_sequencer;

  logic clk;
  logic rst_n;

  fetch_sequencer_if #(.ADDR_W(10)) bus ();

  fetch_sequencer #(.ADDR_W(10), .MEM_BYTES(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [3:0]  nb;
    logic [79:0] by;
    logic [3:0]  ic;
    logic [3:0]  ifn;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] vc;
    logic [63:0] vp;
    logic        iv;
    logic        er;
    logic [7:0]  lat;
    logic [7:0]  rd;
  } vec_t;

  localparam int LEN_TAB [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};

  logic [7:0] rom [0:1023];
  logic [9:0] addr_q [$];
  int         checks = 0;
  int         fails  = 0;
  vec_t       vec [13];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (bus.mem_en) bus.mem_rdata <= rom[bus.mem_addr];
  end

  always @(negedge clk) begin
    if (bus.mem_en) addr_q.push_back(bus.mem_addr);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [63:0] pc, input logic [3:0] nb, input logic [79:0] by,
                              input logic [3:0] ic, input logic [3:0] ifn, input logic [3:0] ra,
                              input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp,
                              input logic iv, input logic er, input logic [7:0] lat, input logic [7:0] rd);
    vec_t v;
    v.pc = pc; v.nb = nb; v.by = by; v.ic = ic; v.ifn = ifn; v.ra = ra; v.rb = rb;
    v.vc = vc; v.vp = vp; v.iv = iv; v.er = er; v.lat = lat; v.rd = rd;
    return v;
  endfunction

  // Reference: instruction semantics straight from the length table and ROM contents.
  function automatic vec_t model(input logic [63:0] pc);
    vec_t        m;
    int          len;
    logic [63:0] a;
    logic [7:0]  b0;
    m    = '0;
    m.pc = pc;
    if (pc >= 64'd1024) begin
      m.er = 1'b1; m.vp = pc; m.lat = 8'd2;
      return m;
    end
    b0   = rom[pc[9:0]];
    len  = LEN_TAB[b0[7:4]];
    m.rd = 8'd1;
    if (pc + 64'(len) > 64'd1024) begin
      m.er = 1'b1; m.vp = pc; m.lat = 8'd3;
      return m;
    end
    m.ic  = b0[7:4];
    m.ifn = b0[3:0];
    m.iv  = (b0[7:4] < 4'hC);
    if (len == 2 || len == 10) begin
      a = pc + 64'd1;
      {m.ra, m.rb} = rom[a[9:0]];
    end
    if (len >= 9) begin
      for (int i = 0; i < 8; i++) begin
        a = pc + 64'(len - 8 + i);
        m.vc[8*i +: 8] = rom[a[9:0]];
      end
    end
    m.vp  = pc + 64'(len);
    m.lat = 8'(len + 2);
    m.rd  = 8'(len);
    return m;
  endfunction

  task automatic load(input vec_t v);
    logic [63:0] a;
    for (int k = 0; k < int'(v.nb); k++) begin
      a = v.pc + 64'(k);
      if (a < 64'd1024) rom[a[9:0]] = v.by[8*k +: 8];
    end
  endtask

  task automatic run_fetch(input vec_t v, input int hold, input bit pulse);
    int          n;
    int          nrd;
    bit          stable;
    logic [63:0] ea;
    @(negedge clk);
    addr_q.delete();
    bus.pc_in = v.pc;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency",     64'(n),               64'(v.lat));
    chk("icode",       64'(bus.icode),       64'(v.ic));
    chk("ifun",        64'(bus.ifun),        64'(v.ifn));
    chk("rA",          64'(bus.rA),          64'(v.ra));
    chk("rB",          64'(bus.rB),          64'(v.rb));
    chk("valC",        bus.valC,             v.vc);
    chk("valP",        bus.valP,             v.vp);
    chk("instr_valid", 64'(bus.instr_valid), 64'(v.iv));
    chk("imem_error",  64'(bus.imem_error),  64'(v.er));
    chk("reads",       64'(addr_q.size()),   64'(v.rd));
    for (int i = 0; i < addr_q.size(); i++) begin
      ea = v.pc + 64'(i);
      chk("mem_addr", 64'(addr_q[i]), 64'(ea[9:0]));
    end
    nrd = addr_q.size();
    if (hold > 0) begin
      stable = 1'b1;
      for (int k = 0; k < hold; k++) begin
        bus.start = pulse & ~k[0];
        @(negedge clk);
        if (!bus.out_valid || bus.valC !== v.vc || bus.valP !== v.vp || bus.icode !== v.ic ||
            bus.rA !== v.ra || bus.rB !== v.rb || bus.imem_error !== v.er)
          stable = 1'b0;
      end
      bus.start = 1'b0;
      chk("hold_stable",   64'(stable),        64'd1);
      chk("hold_no_reads", 64'(addr_q.size()), 64'(nrd));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("valid_drop", 64'(bus.out_valid), 64'd0);
    chk("busy_idle",  64'(bus.busy),      64'd0);
    if (pulse) begin
      @(negedge clk);
      chk("start_ignored", 64'(bus.busy + addr_q.size()), 64'(nrd));
    end
  endtask

  initial begin
    vec_t        rv;
    logic [63:0] pc;
    logic [63:0] a;
    int          nrd;

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.pc_in     = '0;
    bus.stat_in   = 3'b001;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);

    vec[0]  = mk(64'h0,   4'd2,  80'h0010,                    4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 64'h1,   1'b1, 1'b0, 8'd3,  8'd1);
    vec[1]  = mk(64'h10,  4'd10, 80'h0102_0304_0506_0708_F230, 4'h3, 4'h0, 4'hF, 4'h2, 64'h0102030405060708, 64'h1A, 1'b1, 1'b0, 8'd12, 8'd10);
    vec[2]  = mk(64'h20,  4'd9,  80'h0011_2233_4455_6677_8870, 4'h7, 4'h0, 4'h0, 4'h0, 64'h1122334455667788, 64'h29, 1'b1, 1'b0, 8'd11, 8'd9);
    vec[3]  = mk(64'h3FF, 4'd1,  80'h30,                      4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h3FF, 1'b0, 1'b1, 8'd3,  8'd1);
    vec[4]  = mk(64'h400, 4'd0,  80'h0,                       4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h400, 1'b0, 1'b1, 8'd2,  8'd0);
    vec[5]  = mk(64'h40,  4'd1,  80'hC0,                      4'hC, 4'h0, 4'h0, 4'h0, 64'h0, 64'h41,  1'b0, 1'b0, 8'd3,  8'd1);
    vec[6]  = mk(64'h50,  4'd2,  80'h2361,                    4'h6, 4'h1, 4'h2, 4'h3, 64'h0, 64'h52,  1'b1, 1'b0, 8'd4,  8'd2);
    vec[7]  = mk(64'h60,  4'd9,  80'h0001_2345_6789_ABCD_EF80, 4'h8, 4'h0, 4'h0, 4'h0, 64'h0123456789ABCDEF, 64'h69, 1'b1, 1'b0, 8'd11, 8'd9);
    vec[8]  = mk(64'h3FE, 4'd2,  80'h1220,                    4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 64'h400, 1'b1, 1'b0, 8'd4,  8'd2);
    vec[9]  = mk(64'h3F8, 4'd1,  80'h70,                      4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h3F8, 1'b0, 1'b1, 8'd3,  8'd1);
    vec[10] = mk(64'h70,  4'd1,  80'h90,                      4'h9, 4'h0, 4'h0, 4'h0, 64'h0, 64'h71,  1'b1, 1'b0, 8'd3,  8'd1);
    vec[11] = mk(64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 80'h0,        4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 8'd2, 8'd0);
    vec[12] = mk(64'h80,  4'd10, 80'h8000_0000_0000_0088_AB50, 4'h5, 4'h0, 4'hA, 4'hB, 64'h8000000000000088, 64'h8A, 1'b1, 1'b0, 8'd12, 8'd10);

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mem_en",    64'(bus.mem_en),    64'd0);
    chk("rst_busy",      64'(bus.busy),      64'd0);
    chk("rst_halted",    64'(bus.halted),    64'd0);
    chk("rst_fields",    {bus.icode, bus.ifun, bus.rA, bus.rB, 22'd0, bus.mem_addr, bus.instr_valid, bus.imem_error},
                         64'd0);
    chk("rst_valC",      bus.valC,           64'd0);
    chk("rst_valP",      bus.valP,           64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      load(vec[i]);
      run_fetch(vec[i], (i == 2) ? 5 : int'($urandom_range(0, 2)), i == 2);
    end

    // Halt raised mid-way through an irmovq fetch.
    load(vec[1]);
    @(negedge clk);
    addr_q.delete();
    bus.pc_in = 64'h10;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.stat_in = 3'b010;
    @(negedge clk);
    bus.stat_in = 3'b001;
    chk("halt_flag",      64'(bus.halted),    64'd1);
    chk("halt_out_valid", 64'(bus.out_valid), 64'd0);
    chk("halt_mem_en",    64'(bus.mem_en),    64'd0);
    chk("halt_busy",      64'(bus.busy),      64'd0);
    nrd = addr_q.size();
    bus.pc_in = 64'h0;
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    chk("halt_start_ignored", 64'(addr_q.size()), 64'(nrd));
    chk("halt_sticky",        64'(bus.halted),    64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("halt_reset_clears", 64'(bus.halted), 64'd0);
    chk("halt_reset_busy",   64'(bus.busy),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted while reads are still being issued.
    @(negedge clk);
    bus.pc_in = 64'h10;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midfetch_reading", 64'(bus.mem_en), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midfetch_rst_mem_en", 64'(bus.mem_en), 64'd0);
    chk("midfetch_rst_busy",   64'(bus.busy),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_fetch(vec[1], 0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: pc = 64'($urandom_range(0, 1013));
        6, 7:             pc = 64'($urandom_range(1014, 1023));
        8:                pc = 64'($urandom_range(1024, 2047));
        default:          pc = {32'($urandom), 32'($urandom)};
      endcase
      for (int k = 0; k < 10; k++) begin
        a = pc + 64'(k);
        if (a < 64'd1024) rom[a[9:0]] = 8'($urandom);
      end
      rv = model(pc);
      run_fetch(rv, int'($urandom_range(0, 2)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
